// File: rtl/alu_stage.sv
// Single-cycle RV32I execute stage: operands in, registered result/flags/next-PC out.
// Optional macro ALU_BRANCH_EN enables branch/jump target computation on newPC.
module alu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] regdataA,
  input  logic [31:0] regdataB,
  input  logic [31:0] PC,
  input  logic [31:0] immediate,
  input  logic [2:0]  itype,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  regdest,
  input  logic        iOrR,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic [31:0] newPC,
  output logic [4:0]  regdestOut,
  output logic [2:0]  funct3Out,
  output logic [6:0]  funct7Out,
  output logic [6:0]  opcodeOut
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef ALU_BRANCH_EN
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`endif

  logic [31:0] opB, alu_res, pc4;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;
  logic [31:0] result_d, newpc_d;
  logic [2:0]  flags_d;

  logic [31:0] result_q, newpc_q;
  logic [2:0]  flags_q, funct3_q;
  logic [6:0]  funct7_q, opcode_q;
  logic [4:0]  regdest_q;

  assign opB   = iOrR ? immediate : regdataB;
  assign shamt = opB[4:0];
  assign pc4   = PC + 32'd4;
  assign eq    = (regdataA == regdataB);
  assign lt_s  = ($signed(regdataA) < $signed(regdataB));
  assign lt_u  = (regdataA < regdataB);

  always_comb begin
    alu_res = 32'd0;
    case (funct3)
      3'd0: alu_res = (funct7[5] && !iOrR) ? regdataA - opB : regdataA + opB;
      3'd1: alu_res = regdataA << shamt;
      3'd2: alu_res = {31'd0, $signed(regdataA) < $signed(opB)};
      3'd3: alu_res = {31'd0, regdataA < opB};
      3'd4: alu_res = regdataA ^ opB;
      3'd5: alu_res = funct7[5] ? 32'($signed(regdataA) >>> shamt) : regdataA >> shamt;
      3'd6: alu_res = regdataA | opB;
      3'd7: alu_res = regdataA & opB;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    result_d = 32'd0;
    flags_d  = {lt_u, lt_s, eq};
    newpc_d  = pc4;
    case (opcode)
      OP_R, OP_I:         result_d = alu_res;
      OP_LOAD, OP_STORE:  result_d = regdataA + immediate;
      OP_LUI:             result_d = immediate;
      OP_AUIPC:           result_d = PC + immediate;
      OP_JAL, OP_JALR:    result_d = pc4;
      default:            result_d = 32'd0;
    endcase
`ifdef ALU_BRANCH_EN
    // Target selection; branch compares use the raw register operands.
    case (opcode)
      OP_JAL:  newpc_d = PC + immediate;
      OP_JALR: newpc_d = (regdataA + immediate) & ~32'd1;
      OP_BRANCH: begin
        case (funct3)
          3'd0:    newpc_d = eq    ? PC + immediate : pc4;
          3'd1:    newpc_d = !eq   ? PC + immediate : pc4;
          3'd4:    newpc_d = lt_s  ? PC + immediate : pc4;
          3'd5:    newpc_d = !lt_s ? PC + immediate : pc4;
          3'd6:    newpc_d = lt_u  ? PC + immediate : pc4;
          3'd7:    newpc_d = !lt_u ? PC + immediate : pc4;
          default: newpc_d = pc4;
        endcase
      end
      default: newpc_d = pc4;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= 32'd0;
      flags_q   <= 3'd0;
      newpc_q   <= 32'd0;
      regdest_q <= 5'd0;
      funct3_q  <= 3'd0;
      funct7_q  <= 7'd0;
      opcode_q  <= 7'd0;
    end else begin
      result_q  <= result_d;
      flags_q   <= flags_d;
      newpc_q   <= newpc_d;
      regdest_q <= regdest;
      funct3_q  <= funct3;
      funct7_q  <= funct7;
      opcode_q  <= opcode;
    end
  end

  assign result     = result_q;
  assign flags      = flags_q;
  assign newPC      = newpc_q;
  assign regdestOut = regdest_q;
  assign funct3Out  = funct3_q;
  assign funct7Out  = funct7_q;
  assign opcodeOut  = opcode_q;

  logic unused_itype;
  assign unused_itype = ^itype;

endmodule

// File: tb/tb_alu_stage.sv
// Bench for alu_stage: directed vectors, randomized ops vs. a behavioural model, reset checks.
module tb_alu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] regdataA, regdataB, PC, immediate;
  logic [2:0]  itype, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  regdest;
  logic        iOrR;
  logic [31:0] result, newPC;
  logic [2:0]  flags, funct3Out;
  logic [6:0]  funct7Out, opcodeOut;
  logic [4:0]  regdestOut;

  int n_tests = 0;
  int n_fail  = 0;

  alu_stage dut (
    .clk(clk), .rst(rst), .regdataA(regdataA), .regdataB(regdataB), .PC(PC),
    .immediate(immediate), .itype(itype), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .regdest(regdest), .iOrR(iOrR), .result(result), .flags(flags),
    .newPC(newPC), .regdestOut(regdestOut), .funct3Out(funct3Out),
    .funct7Out(funct7Out), .opcodeOut(opcodeOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic ior, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [31:0] pc);
    logic [31:0] ob;
    int          sh;
    longint      sa, sb;
    ob = ior ? imm : b;
    sh = int'(ob % 32);
    sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = ob[31] ? longint'(ob) - 64'sd4294967296 : longint'(ob);
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: return (f7[5] && !ior) ? 32'(longint'(a) - longint'(ob)) : 32'(longint'(a) + longint'(ob));
        3'd1: return 32'(longint'(a) * (64'sd1 << sh));
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (longint'(a) < longint'(ob)) ? 32'd1 : 32'd0;
        3'd4: return a ^ ob;
        3'd5: begin
          if (f7[5] && a[31]) return 32'(sa / (64'sd1 << sh) - (((sa % (64'sd1 << sh)) != 0) ? 1 : 0));
          return 32'(longint'(a) / (64'sd1 << sh));
        end
        3'd6: return a | ob;
        default: return a & ob;
      endcase
    end
    if (op == 7'h03 || op == 7'h23) return 32'(longint'(a) + longint'(imm));
    if (op == 7'h37) return imm;
    if (op == 7'h17) return 32'(longint'(pc) + longint'(imm));
    if (op == 7'h6F || op == 7'h67) return 32'(longint'(pc) + 4);
    return 32'd0;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
    return {(longint'(a) < longint'(b)), (sa < sb), (a == b)};
  endfunction

  function automatic logic [31:0] ref_newpc(input logic [6:0] op, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
    logic [31:0] seq;
    seq = 32'(longint'(pc) + 4);
`ifdef ALU_BRANCH_EN
    begin
      logic [2:0] fl;
      logic       taken;
      fl = ref_flags(a, b);
      if (op == 7'h6F) return 32'(longint'(pc) + longint'(imm));
      if (op == 7'h67) return 32'(longint'(a) + longint'(imm)) & 32'hFFFF_FFFE;
      if (op == 7'h63) begin
        case (f3)
          3'd0: taken = fl[0];
          3'd1: taken = !fl[0];
          3'd4: taken = fl[1];
          3'd5: taken = !fl[1];
          3'd6: taken = fl[2];
          3'd7: taken = !fl[2];
          default: taken = 1'b0;
        endcase
        return taken ? 32'(longint'(pc) + longint'(imm)) : seq;
      end
    end
`else
    if (op == 7'h00 && f3 == 3'd0 && a == b && imm == pc) return seq;
`endif
    return seq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".result"}, result, 32'd0);
    chk({tag, ".flags"}, {29'd0, flags}, 32'd0);
    chk({tag, ".newPC"}, newPC, 32'd0);
    chk({tag, ".fields"}, {10'd0, regdestOut, funct3Out, funct7Out, opcodeOut}, 32'd0);
  endtask

  // Drive one op, clock it, check every output against the model.
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic ior, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    opcode = op; funct3 = f3; funct7 = f7; iOrR = ior; regdataA = a; regdataB = b;
    immediate = imm; PC = pc; regdest = rd; itype = 3'($urandom_range(0, 5));
    @(posedge clk); #1;
    chk({tag, ".result"}, result, ref_result(op, f3, f7, ior, a, b, imm, pc));
    chk({tag, ".flags"}, {29'd0, flags}, {29'd0, ref_flags(a, b)});
    chk({tag, ".newPC"}, newPC, ref_newpc(op, f3, a, b, imm, pc));
    chk({tag, ".fields"}, {10'd0, regdestOut, funct3Out, funct7Out, opcodeOut},
        {10'd0, rd, f3, f7, op});
  endtask

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h00, 7'h7F};

  initial begin
    rst = 1'b1;
    {regdataA, regdataB, PC, immediate} = '0;
    {itype, funct3, funct7, opcode, regdest, iOrR} = '0;
    #1;
    chk_zero("reset_init");
    @(posedge clk); #1;
    chk_zero("reset_hold");
    @(negedge clk); rst = 1'b0;

    run_op("add_5_4",   7'h33, 3'd0, 7'h00, 1'b0, 32'd5, 32'd4, 32'd0, 32'h100, 5'd1);
    chk("add_5_4.exact", result, 32'd9);
    run_op("add_ff_ff", 7'h33, 3'd0, 7'h00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h100, 5'd2);
    chk("add_ff_ff.exact", result, 32'hFFFFFFFE);
    run_op("add_wrap",  7'h33, 3'd0, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h100, 5'd3);
    chk("add_wrap.exact", {flags[0], result[30:0]}, 32'd0);
    run_op("addi_wrap", 7'h13, 3'd0, 7'h00, 1'b1, 32'hFFFFFFFF, 32'd100, 32'd1, 32'h100, 5'd4);
    chk("addi_wrap.exact", result, 32'd0);
    run_op("addi_5_4",  7'h13, 3'd0, 7'h00, 1'b1, 32'd5, 32'd100, 32'd4, 32'h100, 5'd5);
    run_op("sll",       7'h33, 3'd1, 7'h00, 1'b0, 32'd5, 32'd4, 32'd0, 32'h100, 5'd6);
    chk("sll.exact", result, 32'h50);
    run_op("sra",       7'h33, 3'd5, 7'h20, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'h100, 5'd7);
    chk("sra.exact", result, 32'hF8000000);
    run_op("srl",       7'h33, 3'd5, 7'h00, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'h100, 5'd8);
    chk("srl.exact", result, 32'h08000000);
    run_op("sub",       7'h33, 3'd0, 7'h20, 1'b0, 32'd3, 32'd5, 32'd0, 32'h100, 5'd9);
    chk("sub.exact", result, 32'hFFFFFFFE);
    run_op("slt",       7'h33, 3'd2, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h100, 5'd10);
    chk("slt.exact", result, 32'd1);
    run_op("sltu",      7'h33, 3'd3, 7'h00, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h100, 5'd11);
    chk("sltu.exact", result, 32'd0);
    run_op("lui",       7'h37, 3'd0, 7'h00, 1'b1, 32'd1, 32'd2, 32'hABCDE000, 32'h100, 5'd12);
    run_op("auipc",     7'h17, 3'd0, 7'h00, 1'b1, 32'd1, 32'd2, 32'h1000, 32'h200, 5'd13);
    run_op("beq_t",     7'h63, 3'd0, 7'h00, 1'b0, 32'd7, 32'd7, 32'h10, 32'h100, 5'd0);
    run_op("bne_nt",    7'h63, 3'd1, 7'h00, 1'b0, 32'd7, 32'd7, 32'h10, 32'h100, 5'd0);
    chk("bne_nt.exact", newPC, 32'h104);
    run_op("jalr",      7'h67, 3'd0, 7'h00, 1'b1, 32'h201, 32'd0, 32'd2, 32'h100, 5'd1);
    chk("jalr.result", result, 32'h104);
`ifdef ALU_BRANCH_EN
    chk("jalr.exact", newPC, 32'h202);
`endif
    run_op("unknown",   7'h7F, 3'd7, 7'h7F, 1'b0, 32'hFFFF, 32'h1, 32'h5, 32'h100, 5'd31);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("rand", ops[$urandom_range(0, 10)], 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
             1'($urandom), a, b, $urandom, $urandom, 5'($urandom));
    end

    // Mid-cycle asynchronous reset with nonzero outputs pending.
    run_op("pre_rst", 7'h33, 3'd6, 7'h00, 1'b0, 32'h1234, 32'h8001, 32'd0, 32'h400, 5'd9);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    @(posedge clk); #1;
    chk_zero("rst_held");
    @(negedge clk); rst = 1'b0;
    #1 chk_zero("rst_released");
    run_op("post_rst", 7'h33, 3'd0, 7'h00, 1'b0, 32'd10, 32'd20, 32'd0, 32'h500, 5'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
